// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/ack channel plus the issue
// channel toward the decoder and the branch resolution it returns.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;
    logic [31:0]       instr;
    logic [5:0]        op;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        branch;
    logic              branch_taken;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] link_pc;

    modport master (
        output imem_req, imem_addr, instr, op, instr_valid, link_pc,
        input  imem_ack, imem_data, instr_ready, branch, branch_taken, reg_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, op, instr_valid, link_pc,
        output imem_ack, imem_data, instr_ready, branch, branch_taken, reg_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// KGP-RISC fetch/issue stage: owns the PC, fetches one word at a time and
// hands it to the decoder, then picks the next PC from the branch resolution.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus,
    output logic [15:0]   issue_count
);
    localparam logic [ADDR_W-1:0] ONE        = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] RESET_LINK = RESET_PC + ONE;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        ISSUE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] br_target_s;
    logic [ADDR_W-1:0] link_pc_r;
    logic [31:0]       instr_r;
    logic              imem_req_r;
    logic              instr_valid_r;
    logic [15:0]       issue_count_r;
    logic              capture_s;
    logic              accept_s;

    // 26-bit PC-relative offset widened with its sign to the address width.
    function automatic logic [ADDR_W-1:0] sext_offset(input logic [25:0] off);
        logic [ADDR_W-1:0] r;
        r       = {ADDR_W{off[25]}};
        r[25:0] = off;
        return r;
    endfunction

    assign pc_inc_s    = pc_r + ONE;
    assign br_target_s = pc_inc_s + sext_offset(instr_r[25:0]);

    // Next-state decode; ack is only honoured in FETCH, ready only in ISSUE.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    capture_s    = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    accept_s     = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Next-PC selection, using the branch resolution only in the accept cycle.
    always_comb begin
        pc_next_s = pc_r;
        if (accept_s) begin
            case (bus.branch)
                2'b01: begin
                    if (bus.branch_taken) begin
                        pc_next_s = br_target_s;
                    end else begin
                        pc_next_s = pc_inc_s;
                    end
                end
                2'b10:   pc_next_s = bus.reg_target;
                default: pc_next_s = pc_inc_s;
            endcase
        end else begin
            pc_next_s = pc_r;
        end
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            imem_req_r    <= (state_next_s == FETCH);
            instr_valid_r <= (state_next_s == ISSUE);
        end
    end

    // Program counter and accepted-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r          <= RESET_PC;
            issue_count_r <= 16'h0000;
        end else begin
            pc_r <= pc_next_s;
            if (accept_s) begin
                issue_count_r <= issue_count_r + 16'h0001;
            end
        end
    end

    // Issue register: captured word and its link value, frozen until next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_r   <= 32'h0000_0000;
            link_pc_r <= RESET_LINK;
        end else if (capture_s) begin
            instr_r   <= bus.imem_data;
            link_pc_r <= pc_inc_s;
        end
    end

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.instr       = instr_r;
    assign bus.op          = instr_r[31:26];
    assign bus.instr_valid = instr_valid_r;
    assign bus.link_pc     = link_pc_r;
    assign issue_count     = issue_count_r;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized transactions
// checked against a transaction-level PC/count model.
module tb_instr_fetch_unit;
    localparam int AW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] issue_count;
    logic [15:0] issue_count_w;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [31:0] m_pc;
    int unsigned m_count;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(AW)) bus  ();
    instr_fetch_if #(.ADDR_W(AW)) busw ();

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus), .issue_count(issue_count)
    );

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(rst), .bus(busw), .issue_count(issue_count_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input logic [1:0] br, input logic tk,
                                               input logic [31:0] tgt);
        longint off;
        case (br)
            2'b01: begin
                if (tk) begin
                    off = longint'(word[25:0]);
                    if (word[25]) off = off - 64'sd67108864;
                    return 32'(longint'(pc) + 64'sd1 + off);
                end
                return pc + 32'd1;
            end
            2'b10:   return tgt;
            default: return pc + 32'd1;
        endcase
    endfunction

    // One full fetch/issue/accept transaction; entered and left in FETCH.
    task automatic do_instr(input logic [31:0] word, input int waits, input int stalls,
                            input logic [1:0] br, input logic tk, input logic [31:0] tgt);
        logic [31:0] nxt;
        chk("fetch_req", 64'(bus.imem_req), 64'd1);
        chk("fetch_addr", 64'(bus.imem_addr), 64'(m_pc));
        chk("fetch_valid", 64'(bus.instr_valid), 64'd0);
        for (int w = 0; w < waits; w++) begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = $urandom;
            tick();
            chk("wait_addr", 64'(bus.imem_addr), 64'(m_pc));
            chk("wait_req", 64'(bus.imem_req), 64'd1);
            chk("wait_valid", 64'(bus.instr_valid), 64'd0);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = word;
        tick();
        bus.imem_ack  = 1'b0;
        bus.imem_data = $urandom;
        chk("issue_valid", 64'(bus.instr_valid), 64'd1);
        chk("issue_instr", 64'(bus.instr), 64'(word));
        chk("issue_op", 64'(bus.op), 64'(word[31:26]));
        chk("issue_link", 64'(bus.link_pc), 64'(m_pc + 32'd1));
        chk("issue_req", 64'(bus.imem_req), 64'd0);
        for (int s = 0; s < stalls; s++) begin
            bus.instr_ready = 1'b0;
            bus.imem_ack    = 1'($urandom_range(0, 1));
            bus.imem_data   = ~word;
            bus.branch      = 2'($urandom);
            tick();
            chk("stall_valid", 64'(bus.instr_valid), 64'd1);
            chk("stall_instr", 64'(bus.instr), 64'(word));
            chk("stall_op", 64'(bus.op), 64'(word[31:26]));
            chk("stall_link", 64'(bus.link_pc), 64'(m_pc + 32'd1));
            chk("stall_req", 64'(bus.imem_req), 64'd0);
            chk("stall_count", 64'(issue_count), 64'(m_count));
        end
        bus.imem_ack     = 1'b0;
        bus.instr_ready  = 1'b1;
        bus.branch       = br;
        bus.branch_taken = tk;
        bus.reg_target   = tgt;
        nxt = model_next(m_pc, word, br, tk, tgt);
        tick();
        bus.instr_ready  = 1'b0;
        bus.branch       = 2'($urandom);
        bus.branch_taken = 1'($urandom);
        bus.reg_target   = $urandom;
        m_pc    = nxt;
        m_count = (m_count + 1) % 65536;
        chk("accept_count", 64'(issue_count), 64'(m_count));
        chk("accept_valid", 64'(bus.instr_valid), 64'd0);
        chk("accept_req", 64'(bus.imem_req), 64'd1);
        chk("accept_addr", 64'(bus.imem_addr), 64'(m_pc));
    endtask

    initial begin
        logic [31:0] word_b;
        logic [1:0]  br;
        rst              = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_data    = 32'h0;
        bus.instr_ready  = 1'b0;
        bus.branch       = 2'b00;
        bus.branch_taken = 1'b0;
        bus.reg_target   = 32'h0;
        busw.imem_ack     = 1'b1;
        busw.imem_data    = 32'h0400_0000;
        busw.instr_ready  = 1'b1;
        busw.branch       = 2'b00;
        busw.branch_taken = 1'b0;
        busw.reg_target   = 32'h0;
        tick();
        tick();
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_instr", 64'(bus.instr), 64'd0);
        chk("rst_op", 64'(bus.op), 64'd0);
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_link", 64'(bus.link_pc), 64'd1);
        chk("rst_count", 64'(issue_count), 64'd0);
        chk("rstw_addr", 64'(busw.imem_addr), 64'hFFFF_FFFF);
        chk("rstw_link", 64'(busw.link_pc), 64'd0);

        rst = 1'b1;
        cyc = 0;
        m_pc = 32'h0;
        m_count = 0;
        chk("cyc0_req", 64'(bus.imem_req), 64'd0);
        tick();
        chk("wrap_first_addr", 64'(busw.imem_addr), 64'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            chk("seq_cycle", 64'(cyc), 64'(2 * i + 1));
            if (i == 1) begin
                chk("wrap_addr", 64'(busw.imem_addr), 64'd0);
                chk("wrap_req", 64'(busw.imem_req), 64'd1);
            end
            do_instr(32'h0400_0000, 0, 0, 2'b00, 1'b0, 32'h0);
        end
        chk("seq_count3", 64'(issue_count), 64'd3);

        do_instr($urandom, 0, 5, 2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            br = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            do_instr($urandom, $urandom_range(0, 2), $urandom_range(0, 2), br, 1'($urandom), $urandom);
        end
        chk("at_pc10", 64'(bus.imem_addr), 64'd10);

        word_b = {6'b000010, 26'h3FF_FFFC};
        do_instr(word_b, 0, 2, 2'b01, 1'b1, 32'h0);
        chk("br_taken_addr", 64'(bus.imem_addr), 64'd7);
        do_instr($urandom, 0, 0, 2'b10, 1'b0, 32'd10);
        do_instr(word_b, 1, 1, 2'b01, 1'b0, 32'h0);
        chk("br_not_taken_addr", 64'(bus.imem_addr), 64'd11);
        do_instr($urandom, 0, 0, 2'b10, 1'b0, 32'h100);
        chk("reg_ind_addr", 64'(bus.imem_addr), 64'h100);

        for (int i = 0; i < 40; i++) begin
            do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     2'($urandom), 1'($urandom), $urandom);
        end

        bus.imem_ack = 1'b0;
        tick();
        chk("pre_rst_req", 64'(bus.imem_req), 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst_req", 64'(bus.imem_req), 64'd0);
        chk("midrst_addr", 64'(bus.imem_addr), 64'd0);
        chk("midrst_count", 64'(issue_count), 64'd0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hDEAD_BEEF;
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;
        tick();
        bus.imem_ack = 1'b0;
        chk("idle_ack_valid", 64'(bus.instr_valid), 64'd0);
        chk("idle_ack_instr", 64'(bus.instr), 64'd0);
        chk("post_rst_req", 64'(bus.imem_req), 64'd1);
        chk("post_rst_addr", 64'(bus.imem_addr), 64'd0);
        m_pc = 32'h0;
        m_count = 0;
        for (int i = 0; i < 4; i++) begin
            do_instr($urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                     2'($urandom), 1'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and issue stage for the KGP-RISC core. It is the producer side of the opcode/branch interface that the control unit consumes. The block owns the program counter, fetches instruction words over a request/acknowledge handshake, and presents each word (opcode in bits [31:26]) to the decoder with a valid/ready handshake. On acceptance it uses the decoder's `branch` code and the ALU condition to select the next PC.

## Interface
Parameters:
- `ADDR_W`, 32: PC / instruction-memory address width, word-addressed.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request, held until ack.
- `imem_addr` output ADDR_W: fetch address (= PC), stable while `imem_req`=1.
- `imem_ack` input 1: memory returns `imem_data` this cycle.
- `imem_data` input 32: instruction word.
- `instr` output 32: issued instruction register.
- `op` output 6: `instr[31:26]`, to control unit.
- `instr_valid` output 1: `instr` holds an unconsumed instruction.
- `instr_ready` input 1: downstream accepts `instr` this cycle.
- `branch` input 2: from control unit, decoded from `op`. 00 sequential, 01 PC-relative, 10 register-indirect, 11 treated as 00.
- `branch_taken` input 1: condition result for `branch`=01 (1 for unconditional b/bl).
- `reg_target` input ADDR_W: register-indirect target for `branch`=10.
- `link_pc` output ADDR_W: PC+1 of the issued instruction (bl link value, `mem_reg_PC`=11).
- `issue_count` output 16: instructions accepted since reset.

## Operation
- States: IDLE, FETCH, ISSUE.
- IDLE: entered on reset. Leaves to FETCH on the first clock after reset deassertion.
- FETCH: `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack`=1, capture `imem_data` into `instr`, go to ISSUE.
  - With no ack, stay in FETCH. Address is held.
- ISSUE: `instr_valid`=1. `instr`, `op` and `link_pc` are held stable while `instr_ready`=0.
  - On `instr_ready`=1, PC is updated, `issue_count` increments, and the state goes to FETCH.
- Next PC, evaluated in the accept cycle (`branch`/`branch_taken`/`reg_target` are sampled only then):
  - `branch`=00 or 11: PC+1.
  - `branch`=01 and `branch_taken`=1: PC+1+sext(`instr[25:0]`).
  - `branch`=01 and `branch_taken`=0: PC+1.
  - `branch`=10: `reg_target`.
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W. PC=2^ADDR_W−1 sequential wraps to 0.
  - The offset is sign-extended from bit 25 to ADDR_W.
- `link_pc` = PC+1 (mod 2^ADDR_W) of the instruction in `instr`.
- `issue_count` wraps from 0xFFFF to 0.
- `imem_ack` in IDLE or ISSUE is ignored. No capture occurs and the state does not change.
- Reset mid-operation: all state clears immediately and asynchronously. An outstanding fetch is abandoned. An ack arriving after reset, while in IDLE, is ignored.

## Timing
- Reset values:
  - State IDLE, PC=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr`=0, `op`=0, `instr_valid`=0.
  - `link_pc`=`RESET_PC`+1, `issue_count`=0.
- Cycle 0 after reset release is IDLE. `imem_req` rises in cycle 1.
- Ack latency: `instr_valid` rises the cycle after `imem_ack`=1. Zero-wait ack (ack in the first FETCH cycle) is legal.
- Throughput: with zero-wait memory and `instr_ready` tied high, one instruction per 2 cycles (FETCH, ISSUE).
- Taken branch: new `imem_addr` appears in the cycle after the accept cycle. There is no penalty beyond the sequential case and no speculative fetch.
- `imem_req`, `imem_addr`, `instr_valid`, `instr`, `op`, `link_pc` and `issue_count` are registered or decoded from registered state only. There are no combinational paths from inputs.

## Test plan
- Reset, then zero-wait memory returning 0x04000000 (op 000001) with `instr_ready`=1 and `branch`=00:
  - `imem_addr` sequence 0,1,2 on cycles 1,3,5.
  - `issue_count`=3 after the third accept.
- Backpressure: hold `instr_ready`=0 for 5 cycles in ISSUE.
  - `instr_valid`, `instr` and `op` stay constant, `imem_req`=0.
  - Release gives exactly one accept.
- Branch from PC=10 with `branch`=01:
  - `instr[25:0]`=0x3FFFFFC and taken gives next `imem_addr`=7.
  - Same instruction with `branch_taken`=0 gives 11.
  - `link_pc`=11 throughout.
- `branch`=10 with `reg_target`=0x100 gives next `imem_addr`=0x100.
- Wrap: `RESET_PC`=0xFFFFFFFF with a sequential accept gives `imem_addr`=0.
- Wait-state and reset:
  - Ack delayed 3 cycles keeps `imem_addr` stable throughout.
  - Assert `rst`=0 mid-FETCH: `imem_req` drops immediately and state returns to IDLE.
  - An ack pulsed in IDLE is ignored and `instr_valid` stays 0.
